// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: merges stage stall requests and sequences exception/ERET and branch-mispredict flushes.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int          STALL_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic               mem_busy_i,
  input  logic               exception_i,
  input  logic               eret_i,
  input  logic               exception_first_inst_i,
  input  logic [31:0]        epc_i,
  input  logic               bp_flush_i,
  input  logic [31:0]        bp_target_i,
  output logic [STALL_W-1:0] stall_o,
  output logic               flush_o,
  output logic               flush_cause_o,
  output logic               exception_first_inst_o,
  output logic [31:0]        new_pc_o
);
  typedef enum logic [1:0] {IDLE, EXC_WAIT, FLUSH} state_t;
  state_t      state_q, state_d;
  logic        br_pending_q, br_pending_d;
  logic [31:0] br_target_q, br_target_d;
  logic [31:0] target_q, target_d;
  logic        cause_q, cause_d;
  logic        first_q, first_d;
  logic [STALL_W-1:0] stall_idle;
  assign stall_idle = {1'b0, stallreq_mem, stallreq_mem | stallreq_ex,
                       stallreq_mem | stallreq_ex | stallreq_id,
                       stallreq_mem | stallreq_ex | stallreq_id | stallreq_if};
  assign stall_o = state_q == EXC_WAIT ? '1 : state_q == FLUSH ? '0 : stall_idle;
  assign flush_o = state_q == FLUSH;
  assign flush_cause_o = cause_q;
  assign exception_first_inst_o = first_q;
  assign new_pc_o = target_q;
  always_comb begin
    state_d      = state_q;
    br_pending_d = br_pending_q;
    br_target_d  = br_target_q;
    target_d     = target_q;
    cause_d      = cause_q;
    first_d      = first_q;
    if (state_q == IDLE) begin
      if (exception_i || eret_i) begin
        // exception outranks a simultaneous eret, so the vector wins
        target_d     = exception_i ? EXC_VECTOR : epc_i;
        first_d      = exception_first_inst_i;
        cause_d      = 1'b1;
        br_pending_d = 1'b0;
        state_d      = mem_busy_i ? EXC_WAIT : FLUSH;
      end else if (bp_flush_i || br_pending_q) begin
        if (!stall_idle[2]) begin
          cause_d      = 1'b0;
          target_d     = bp_flush_i ? bp_target_i : br_target_q;
          br_pending_d = 1'b0;
          state_d      = FLUSH;
        end else if (bp_flush_i && !br_pending_q) begin
          br_pending_d = 1'b1;
          br_target_d  = bp_target_i;
        end
      end
    end else if (state_q == EXC_WAIT) begin
      state_d = mem_busy_i ? EXC_WAIT : FLUSH;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      br_pending_q <= 1'b0;
      br_target_q  <= '0;
      target_q     <= '0;
      cause_q      <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      br_pending_q <= br_pending_d;
      br_target_q  <= br_target_d;
      target_q     <= target_d;
      cause_q      <= cause_d;
      first_q      <= first_d;
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vectors with hand-computed expectations for pipeline_ctrl.
module tb_pipeline_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic        mem_busy_i = 1'b0, exception_i = 1'b0, eret_i = 1'b0, exception_first_inst_i = 1'b0;
  logic [31:0] epc_i = '0, bp_target_i = '0;
  logic        bp_flush_i = 1'b0;
  logic [4:0]  stall_o;
  logic        flush_o, flush_cause_o, exception_first_inst_o;
  logic [31:0] new_pc_o;
  int          n_run = 0, n_fail = 0;
  pipeline_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .mem_busy_i(mem_busy_i), .exception_i(exception_i), .eret_i(eret_i),
    .exception_first_inst_i(exception_first_inst_i), .epc_i(epc_i),
    .bp_flush_i(bp_flush_i), .bp_target_i(bp_target_i),
    .stall_o(stall_o), .flush_o(flush_o), .flush_cause_o(flush_cause_o),
    .exception_first_inst_o(exception_first_inst_o), .new_pc_o(new_pc_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    step();
    check("rst_stall", 32'(stall_o), 32'h0);
    check("rst_flush", 32'(flush_o), 32'h0);
    check("rst_pc", new_pc_o, 32'h0);
    check("rst_cause", 32'(flush_cause_o), 32'h0);
    rst = 1'b1;
    step();
    check("idle_stall", 32'(stall_o), 32'h0);
    stallreq_id = 1'b1; stallreq_mem = 1'b1; #1;
    check("stall_id_mem", 32'(stall_o), 32'h0F);
    stallreq_id = 1'b0; stallreq_mem = 1'b0; stallreq_if = 1'b1; #1;
    check("stall_if", 32'(stall_o), 32'h01);
    stallreq_if = 1'b0; stallreq_ex = 1'b1; #1;
    check("stall_ex", 32'(stall_o), 32'h07);
    stallreq_ex = 1'b0;
    exception_i = 1'b1; exception_first_inst_i = 1'b1;
    step();
    exception_i = 1'b1; stallreq_mem = 1'b1; exception_first_inst_i = 1'b0; #1;
    check("exc_flush", 32'(flush_o), 32'h1);
    check("exc_cause", 32'(flush_cause_o), 32'h1);
    check("exc_pc", new_pc_o, 32'hBFC00380);
    check("exc_first", 32'(exception_first_inst_o), 32'h1);
    check("exc_stall", 32'(stall_o), 32'h0);
    step();
    exception_i = 1'b0; stallreq_mem = 1'b0;
    check("exc_flush_end", 32'(flush_o), 32'h0);
    step();
    check("flush_ignores_exc", 32'(flush_o), 32'h0);
    eret_i = 1'b1; epc_i = 32'h80001234; mem_busy_i = 1'b1;
    step();
    eret_i = 1'b0;
    check("eret_wait1", 32'(stall_o), 32'h1F);
    check("eret_noflush1", 32'(flush_o), 32'h0);
    step();
    exception_i = 1'b1; #1;
    check("eret_wait2", 32'(stall_o), 32'h1F);
    step();
    exception_i = 1'b0; mem_busy_i = 1'b0; #1;
    check("eret_wait3", 32'(stall_o), 32'h1F);
    step();
    check("eret_flush", 32'(flush_o), 32'h1);
    check("eret_pc", new_pc_o, 32'h80001234);
    check("eret_cause", 32'(flush_cause_o), 32'h1);
    check("eret_first", 32'(exception_first_inst_o), 32'h0);
    step();
    check("eret_flush_end", 32'(flush_o), 32'h0);
    bp_flush_i = 1'b1; bp_target_i = 32'h80000100; stallreq_ex = 1'b1;
    step();
    bp_target_i = 32'h80000200;
    check("bp_held1", 32'(flush_o), 32'h0);
    step();
    bp_flush_i = 1'b0; stallreq_ex = 1'b0;
    check("bp_held2", 32'(flush_o), 32'h0);
    step();
    check("bp_flush", 32'(flush_o), 32'h1);
    check("bp_cause", 32'(flush_cause_o), 32'h0);
    check("bp_pc", new_pc_o, 32'h80000100);
    step();
    check("bp_flush_end", 32'(flush_o), 32'h0);
    exception_i = 1'b1; bp_flush_i = 1'b1; bp_target_i = 32'h80000300;
    step();
    exception_i = 1'b0; bp_flush_i = 1'b0;
    check("exbp_flush", 32'(flush_o), 32'h1);
    check("exbp_cause", 32'(flush_cause_o), 32'h1);
    check("exbp_pc", new_pc_o, 32'hBFC00380);
    step();
    check("exbp_end", 32'(flush_o), 32'h0);
    step();
    check("exbp_no_bp", 32'(flush_o), 32'h0);
    eret_i = 1'b1; exception_i = 1'b1; epc_i = 32'h80001234;
    step();
    eret_i = 1'b0; exception_i = 1'b0;
    check("ereexc_pc", new_pc_o, 32'hBFC00380);
    step();
    exception_i = 1'b1; exception_first_inst_i = 1'b1; mem_busy_i = 1'b1;
    step();
    exception_i = 1'b0;
    check("rstw_stall", 32'(stall_o), 32'h1F);
    rst = 1'b0; #1;
    check("rstw_flush", 32'(flush_o), 32'h0);
    check("rstw_stall0", 32'(stall_o), 32'h0);
    check("rstw_pc", new_pc_o, 32'h0);
    check("rstw_cause", 32'(flush_cause_o), 32'h0);
    check("rstw_first", 32'(exception_first_inst_o), 32'h0);
    mem_busy_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("rstw_noflush1", 32'(flush_o), 32'h0);
    step();
    check("rstw_noflush2", 32'(flush_o), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
